// File: rtl/dmem_stage_m.sv
// rtl/dmem_stage_m.sv - M-stage data memory with M/W load-data register (optional alignment check: DMEM_ALIGN_CHK_EN)
module dmem_stage_m #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    input  logic        memwrite_M,
    input  logic        sb,
    input  logic        memtoreg_M,
    input  logic        lb_memtoreg_M,
    output logic [31:0] rdata_W,
    output logic        ld_W,
    output logic        err_W,
    output logic [7:0]  err_count
);

    logic [31:0]   mem_q [WORDS];
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic          misalign;

    logic          wr_en_d;
    logic [31:0]   wr_word_d;
    logic [31:0]   rdata_d, rdata_q;
    logic          ld_d, ld_q;
    logic          err_d, err_q;
    logic [7:0]    cnt_d, cnt_q;

    // Address bits above the word index wrap the address space and are never looked at.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_M[31:AW+2];

    assign widx    = addr_M[AW+1:2];
    assign lane    = addr_M[1:0];
    assign rd_word = mem_q[widx];

    // Select the addressed byte lane of the current word (little-endian).
    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    // Word-sized accesses with a nonzero byte offset are misaligned; byte accesses never are.
    always_comb begin
        misalign = (lane != 2'b00) &&
                   ((memwrite_M && !sb) || (memtoreg_M && !lb_memtoreg_M));
    end

`ifndef DMEM_ALIGN_CHK_EN
    logic unused_misalign;
    assign unused_misalign = misalign;
`endif

    // Build the word to write back: full word, or the old word with one lane replaced.
    always_comb begin
        wr_en_d   = memwrite_M;
        wr_word_d = wdata_M;
        if (sb) begin
            wr_word_d = rd_word;
            case (lane)
                2'd0: wr_word_d[7:0]   = wdata_M[7:0];
                2'd1: wr_word_d[15:8]  = wdata_M[7:0];
                2'd2: wr_word_d[23:16] = wdata_M[7:0];
                2'd3: wr_word_d[31:24] = wdata_M[7:0];
                default: wr_word_d = rd_word;
            endcase
        end
`ifdef DMEM_ALIGN_CHK_EN
        if (!sb && misalign) begin
            wr_en_d = 1'b0;
        end
`endif
    end

    // Load result, valid flag and misalignment bookkeeping for the W stage.
    always_comb begin
        ld_d    = lb_memtoreg_M | memtoreg_M;
        rdata_d = 32'h0;
        if (lb_memtoreg_M) begin
            rdata_d = {{24{rd_byte[7]}}, rd_byte};
        end else if (memtoreg_M) begin
            rdata_d = rd_word;
`ifdef DMEM_ALIGN_CHK_EN
            if (misalign) begin
                rdata_d = 32'h0;
            end
`endif
        end
`ifdef DMEM_ALIGN_CHK_EN
        err_d = misalign;
        cnt_d = (misalign && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
`else
        err_d = 1'b0;
        cnt_d = 8'h0;
`endif
    end

    // Memory array: cleared by reset, one word written per store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (wr_en_d) begin
            mem_q[widx] <= wr_word_d;
        end
    end

    // M/W pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            rdata_q <= rdata_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rdata_W   = rdata_q;
    assign ld_W      = ld_q;
    assign err_W     = err_q;
    assign err_count = cnt_q;

endmodule
